// File: rtl/conv_window_gen_pkg.sv
// conv_window_gen_pkg: kernel geometry, default widths and window packing shared with the convolution datapath.
package conv_window_gen_pkg;
    localparam int KERNEL_SIZE           = 3;
    localparam int KERNEL_DATA_WIDTH_DEF = 8;
    localparam int MAX_IMG_WIDTH_DEF     = 256;

    function automatic int win_idx(input int r, input int c);
        return r * KERNEL_SIZE + c;
    endfunction
endpackage

// File: rtl/conv_line_buffer.sv
// conv_line_buffer: delay line of runtime length len, read-before-write, advancing only when en is high.
module conv_line_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int LEN_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              restart,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     ptr, addr;
    logic [LEN_W-1:0]  nxt;

    // restarting at address 0 on each frame keeps the delay exact even if len changed
    assign addr = restart ? '0 : ptr;
    assign nxt  = LEN_W'(addr) + LEN_W'(1);
    assign dout = mem[addr];

    always_ff @(posedge clk)
        if (en) mem[addr] <= din;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ptr <= '0;
        else if (en) ptr <= (nxt >= len) ? '0 : AW'(nxt);
endmodule

// File: rtl/conv_window_gen.sv
// conv_window_gen: raster pixel stream to dilated 3x3 windows using line buffers and per-row shift registers.
module conv_window_gen
    import conv_window_gen_pkg::*;
#(
    parameter int  KERNEL_DATA_WIDTH = KERNEL_DATA_WIDTH_DEF,
    parameter int  MAX_IMG_WIDTH     = MAX_IMG_WIDTH_DEF,
    parameter int  DILATION          = 1,
    localparam int DIM_W             = $clog2(MAX_IMG_WIDTH + 1)
) (
    input  logic                                                clk,
    input  logic                                                rst_n,
    input  logic                                                pipe_flush_i,
    input  logic                                                pixel_valid_i,
    input  logic [KERNEL_DATA_WIDTH-1:0]                        pixel_data_i,
    input  logic [DIM_W-1:0]                                    img_width_i,
    input  logic [DIM_W-1:0]                                    img_height_i,
    output logic                                                window_valid_o,
    output logic [KERNEL_SIZE*KERNEL_SIZE*KERNEL_DATA_WIDTH-1:0] window_data_o,
    output logic                                                frame_done_o
);
    localparam int DW   = KERNEL_DATA_WIDTH;
    localparam int SPAN = 2 * DILATION;
    localparam int NWIN = KERNEL_SIZE * KERNEL_SIZE;

    logic [DIM_W-1:0] col, row, width_q, height_q, width, height;
    logic             first, accept, last_col, last_row, hit;
    logic [DW-1:0]    chain [SPAN+1];
    logic [DW-1:0]    tap [KERNEL_SIZE];
    logic [DW-1:0]    sr [KERNEL_SIZE][SPAN];
    logic [DW-1:0]    px [KERNEL_SIZE][SPAN+1];
    logic [NWIN*DW-1:0] win_next;

    assign accept   = pixel_valid_i && !pipe_flush_i;
    assign first    = (col == '0) && (row == '0);
    assign width    = first ? img_width_i : width_q;
    assign height   = first ? img_height_i : height_q;
    assign last_col = col == width - DIM_W'(1);
    assign last_row = row == height - DIM_W'(1);
    assign hit      = (row >= DIM_W'(SPAN)) && (col >= DIM_W'(SPAN));

    assign chain[0] = pixel_data_i;
    for (genvar k = 0; k < SPAN; k++) begin : g_lb
        conv_line_buffer #(
            .DATA_W (DW),
            .DEPTH  (MAX_IMG_WIDTH),
            .LEN_W  (DIM_W)
        ) u_lb (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (accept),
            .restart (first),
            .len     (width),
            .din     (chain[k]),
            .dout    (chain[k+1])
        );
    end

    // row 0 of the window is the oldest line, row 2 the incoming one
    assign tap[0] = chain[SPAN];
    assign tap[1] = chain[DILATION];
    assign tap[2] = chain[0];

    always_ff @(posedge clk)
        if (accept)
            for (int r = 0; r < KERNEL_SIZE; r++) begin
                sr[r][0] <= tap[r];
                for (int k = 1; k < SPAN; k++) sr[r][k] <= sr[r][k-1];
            end

    always_comb begin
        win_next = '0;
        for (int r = 0; r < KERNEL_SIZE; r++) begin
            px[r][0] = tap[r];
            for (int k = 1; k <= SPAN; k++) px[r][k] = sr[r][k-1];
        end
        for (int r = 0; r < KERNEL_SIZE; r++)
            for (int c = 0; c < KERNEL_SIZE; c++)
                win_next[win_idx(r, c)*DW +: DW] = px[r][(KERNEL_SIZE-1-c)*DILATION];
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            col            <= '0;
            row            <= '0;
            width_q        <= '0;
            height_q       <= '0;
            window_valid_o <= 1'b0;
            frame_done_o   <= 1'b0;
            window_data_o  <= '0;
        end else if (pipe_flush_i) begin
            col            <= '0;
            row            <= '0;
            window_valid_o <= 1'b0;
            frame_done_o   <= 1'b0;
        end else begin
            window_valid_o <= pixel_valid_i && hit;
            frame_done_o   <= pixel_valid_i && last_col && last_row;
            if (pixel_valid_i) begin
                if (first) begin
                    width_q  <= img_width_i;
                    height_q <= img_height_i;
                end
                col <= last_col ? '0 : col + DIM_W'(1);
                row <= last_col ? (last_row ? '0 : row + DIM_W'(1)) : row;
                if (hit) window_data_o <= win_next;
            end
        end
endmodule

// File: doc/conv_window_gen.md
CONV_WINDOW_GEN -- requirements
Module: conv_window_gen

Interface
REQ-001 SHALL have parameter KERNEL_DATA_WIDTH, default 8, pixel width in bits.
REQ-002 SHALL have parameter MAX_IMG_WIDTH, default 256, maximum line length in pixels.
REQ-003 SHALL have parameter DILATION, default 1, legal values 1..4, the row and column tap spacing of the window.
REQ-004 SHALL define localparam DIM_W = clog2(MAX_IMG_WIDTH+1) for the width/height ports.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on the rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-007 SHALL have port pipe_flush_i, input, 1, synchronous abort of the current frame.
REQ-008 SHALL have port pixel_valid_i, input, 1, pixel_data_i is valid this cycle (raster order).
REQ-009 SHALL have port pixel_data_i, input, KERNEL_DATA_WIDTH, one input pixel.
REQ-010 SHALL have port img_width_i, input, DIM_W, line length in pixels.
REQ-011 SHALL have port img_height_i, input, DIM_W, line count.
REQ-012 SHALL have port window_valid_o, input-side handshake to the downstream convolution datapath: output, 1, window_data_o holds a complete 3x3 window.
REQ-013 SHALL have port window_data_o, output, 9*KERNEL_DATA_WIDTH, packed window; element j = r*3+c at bits [(j+1)*KERNEL_DATA_WIDTH-1 : j*KERNEL_DATA_WIDTH]; r=0 is the oldest row, c=0 the oldest column.
REQ-014 SHALL have port frame_done_o, output, 1, one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-015 SHALL provide no back-pressure: every cycle with pixel_valid_i=1 accepts one pixel; cycles with pixel_valid_i=0 change no state.
REQ-016 SHALL latch img_width_i/img_height_i on acceptance of pixel (row 0, col 0); later changes within the frame SHALL be ignored.
REQ-017 SHALL keep col/row counters; col wraps to 0 after img_width-1 and increments row; row wraps to 0 after img_height-1, which ends the frame.
REQ-018 SHALL delay each pixel by exactly img_width accepted pixels per line buffer, using 2*DILATION line buffers in series; row taps are at line-delays 0, DILATION, 2*DILATION.
REQ-019 SHALL hold per tapped row a shift register of 2*DILATION+1 pixels; column taps at positions 0, DILATION, 2*DILATION.
REQ-020 SHALL assert window_valid_o for exactly one cycle, registered one cycle after accepting the pixel at (row, col) with row >= 2*DILATION and col >= 2*DILATION; no padding windows are produced.
REQ-021 SHALL make element 8 equal to that pixel, element 0 equal to the pixel at (row-2D, col-2D), element j equal to the pixel at (row-2D+D*r, col-2D+D*c), where D = DILATION.
REQ-022 SHALL hold window_data_o stable while window_valid_o=0.
REQ-023 SHALL never emit windows when img_width or img_height < 2*DILATION+1; counters and frame_done_o SHALL still operate.
REQ-024 SHALL not require line-buffer clearing between frames; stale contents are never exposed under REQ-020.
REQ-025 SHALL pulse frame_done_o one cycle after the final pixel, coincident with that pixel's window_valid_o if any.
REQ-026 SHALL, on pipe_flush_i, zero the counters, window_valid_o and frame_done_o in the next cycle; flush SHALL win over a simultaneous pixel_valid_i (pixel dropped).

Reset
REQ-027 SHALL on rst_n=0 asynchronously clear the counters, latched dimensions, window_valid_o, frame_done_o and window_data_o to 0; line-buffer RAM contents need not be reset.
REQ-028 SHALL treat reset mid-frame as an abort; the next accepted pixel is (0,0) of a new frame.

Structure
REQ-029 SHALL take KERNEL_SIZE=3, KERNEL_DATA_WIDTH default, MAX_IMG_WIDTH default and the window packing index formula from the shared conv header/package used by the convolution datapath.
REQ-030 SHALL instantiate sub-module conv_line_buffer (single-port-style delay line of depth MAX_IMG_WIDTH, runtime length img_width, read-before-write, advances only on pixel_valid_i), one instance per line-delay.

Verification
REQ-031 SHALL cover: D=1, width=5, height=5, pixels 0..24 back-to-back -> first window_valid_o the cycle after pixel 12, elements {0,1,2,5,6,7,10,11,12}; exactly 9 windows; frame_done_o after pixel 24.
REQ-032 SHALL cover: REQ-031 stimulus with pixel_valid_i low every other cycle -> identical window sequence and values, outputs frozen during gaps.
REQ-033 SHALL cover: D=2, width=7, height=5, pixels 0..34 -> 3 windows; first is {0,2,4,14,16,18,28,30,32}.
REQ-034 SHALL cover: pipe_flush_i asserted with pixel_valid_i at pixel 8 of a 5x5 frame, then a fresh frame of pixels 100..124 -> no window contains values below 100; first window {100,101,102,105,106,107,110,111,112}.
REQ-035 SHALL cover: width=2, height=4, D=1 -> zero windows and one frame_done_o pulse; rst_n pulsed mid-frame -> all outputs 0 immediately, the next frame matches REQ-031.
